// File: rtl/mdu_sched.sv
// mdu_sched -- multiply/divide scheduler for the E stage of a five-stage MIPS
// pipeline. Owns the HI/LO pair, sequences multi-cycle mult/multu/div/divu
// with a down-counter and raises a D-stage stall while the unit is occupied.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low
//   E_MDUop      E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none
//   E_A, E_B     forwarded rs / rt values
//   D_MDU_use    D-stage instruction is an MDU op (1-8)
//   E_MDU_out    HI for mfhi, LO for mflo, else 0 (combinational)
//   E_busy       registered; high while an operation is in flight
//   D_MDU_stall  combinational stall request to the hazard unit
//   E_HI, E_LO   architectural HI/LO registers
module mdu_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUop,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_MDU_use,
    output logic [31:0] E_MDU_out,
    output logic        E_busy,
    output logic        D_MDU_stall,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        start;

    // Full 64-bit product; operands are extended to 64 bits first so the
    // multiply is self-sized and the signed case needs no context tricks.
    function automatic logic [63:0] mul_calc(input logic is_signed,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] as64;
        logic signed [63:0] bs64;
        logic [63:0]        au64;
        logic [63:0]        bu64;
        as64 = {{32{a[31]}}, a};
        bs64 = {{32{b[31]}}, b};
        au64 = {32'd0, a};
        bu64 = {32'd0, b};
        if (is_signed)
            return as64 * bs64;
        return au64 * bu64;
    endfunction

    // Returns {remainder, quotient}. Divide-by-zero and the single signed
    // overflow case are pinned explicitly rather than left to the operator.
    function automatic logic [63:0] div_calc(input logic is_signed,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [31:0] as32;
        logic signed [31:0] bs32;
        logic signed [31:0] q;
        logic signed [31:0] r;
        as32 = a;
        bs32 = b;
        if (b == 32'd0)
            return {a, 32'hFFFF_FFFF};
        if (is_signed) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return {32'd0, 32'h8000_0000};
            q = as32 / bs32;
            r = as32 % bs32;
            return {r, q};
        end
        return {a % b, a / b};
    endfunction

    assign start = (state == IDLE) && (E_MDUop >= OP_MULT) && (E_MDUop <= OP_DIVU);

    assign D_MDU_stall = D_MDU_use && (start || state == BUSY);

    always_comb begin
        E_MDU_out = 32'd0;
        if (E_MDUop == OP_MFHI)
            E_MDU_out = E_HI;
        else if (E_MDUop == OP_MFLO)
            E_MDU_out = E_LO;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            E_HI   <= 32'd0;
            E_LO   <= 32'd0;
            E_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (E_MDUop == OP_MULT || E_MDUop == OP_MULTU) begin
                            {res_hi, res_lo} <= mul_calc(E_MDUop == OP_MULT, E_A, E_B);
                            cnt <= 4'(MULT_CYCLES);
                        end else begin
                            {res_hi, res_lo} <= div_calc(E_MDUop == OP_DIV, E_A, E_B);
                            cnt <= 4'(DIV_CYCLES);
                        end
                        state  <= BUSY;
                        E_busy <= 1'b1;
                    end else if (E_MDUop == OP_MTHI) begin
                        E_HI <= E_A;
                    end else if (E_MDUop == OP_MTLO) begin
                        E_LO <= E_A;
                    end
                end
                BUSY: begin
                    // New MDU ops here are ignored; the stall keeps them out.
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        E_HI   <= res_hi;
                        E_LO   <= res_lo;
                        state  <= IDLE;
                        E_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    E_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sched.sv
module tb_mdu_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  E_MDUop;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_MDU_use;
    logic [31:0] E_MDU_out;
    logic        E_busy;
    logic        D_MDU_stall;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    int checks = 0;
    int fails  = 0;

    mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk),
        .reset(reset),
        .E_MDUop(E_MDUop),
        .E_A(E_A),
        .E_B(E_B),
        .D_MDU_use(D_MDU_use),
        .E_MDU_out(E_MDU_out),
        .E_busy(E_busy),
        .D_MDU_stall(D_MDU_stall),
        .E_HI(E_HI),
        .E_LO(E_LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge (start of the next cycle).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; E_MDUop = 4'd0; E_A = 32'd0; E_B = 32'd0; D_MDU_use = 1'b0;
        step();
        step();
        reset = 1'b1;
        D_MDU_use = 1'b1;
        E_MDUop = 4'd7;
        #1;
        if (E_HI !== 32'd0) begin $display("FAIL reset_hi: got %h want 0", E_HI); fails++; end
        checks++;
        if (E_LO !== 32'd0) begin $display("FAIL reset_lo: got %h want 0", E_LO); fails++; end
        checks++;
        if (E_busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", E_busy); fails++; end
        checks++;
        if (D_MDU_stall !== 1'b0) begin $display("FAIL reset_stall: got %b want 0", D_MDU_stall); fails++; end
        checks++;
        if (E_MDU_out !== 32'd0) begin $display("FAIL reset_mfhi_out: got %h want 0", E_MDU_out); fails++; end
        checks++;
        E_MDUop = 4'd0; D_MDU_use = 1'b0;
    endtask

    // mult -2 * 3 with an mfhi waiting in D throughout.
    task automatic test_mult();
        E_MDUop = 4'd1; E_A = 32'hFFFF_FFFE; E_B = 32'd3; D_MDU_use = 1'b1;
        #1;
        if (D_MDU_stall !== 1'b1) begin $display("FAIL mult_stall_c0: got %b want 1", D_MDU_stall); fails++; end
        checks++;
        if (E_busy !== 1'b0) begin $display("FAIL mult_busy_c0: got %b want 0", E_busy); fails++; end
        checks++;
        for (int k = 1; k <= 5; k++) begin
            step();
            E_MDUop = 4'd0; D_MDU_use = 1'b1;
            #1;
            if (E_busy !== 1'b1) begin $display("FAIL mult_busy_c%0d: got %b want 1", k, E_busy); fails++; end
            checks++;
            if (D_MDU_stall !== 1'b1) begin $display("FAIL mult_stall_c%0d: got %b want 1", k, D_MDU_stall); fails++; end
            checks++;
        end
        step();
        E_MDUop = 4'd7; D_MDU_use = 1'b0;
        #1;
        if (E_busy !== 1'b0) begin $display("FAIL mult_busy_c6: got %b want 0", E_busy); fails++; end
        checks++;
        if (E_HI !== 32'hFFFF_FFFF) begin $display("FAIL mult_hi: got %h want ffffffff", E_HI); fails++; end
        checks++;
        if (E_LO !== 32'hFFFF_FFFA) begin $display("FAIL mult_lo: got %h want fffffffa", E_LO); fails++; end
        checks++;
        if (E_MDU_out !== 32'hFFFF_FFFF) begin $display("FAIL mult_mfhi_out: got %h want ffffffff", E_MDU_out); fails++; end
        checks++;
        if (D_MDU_stall !== 1'b0) begin $display("FAIL mult_stall_c6: got %b want 0", D_MDU_stall); fails++; end
        checks++;
        E_MDUop = 4'd0;
    endtask

    // Divide vectors; non-MDU instructions in D are never stalled.
    task automatic test_div();
        logic [3:0]  ops [5];
        logic [31:0] av  [5];
        logic [31:0] bv  [5];
        logic [31:0] ehi [5];
        logic [31:0] elo [5];
        ops[0] = 4'd3; av[0] = 32'hFFFF_FFF9; bv[0] = 32'd2;          ehi[0] = 32'hFFFF_FFFF; elo[0] = 32'hFFFF_FFFD;
        ops[1] = 4'd4; av[1] = 32'd7;         bv[1] = 32'd0;          ehi[1] = 32'd7;         elo[1] = 32'hFFFF_FFFF;
        ops[2] = 4'd3; av[2] = 32'h8000_0000; bv[2] = 32'hFFFF_FFFF;  ehi[2] = 32'd0;         elo[2] = 32'h8000_0000;
        ops[3] = 4'd3; av[3] = 32'd7;         bv[3] = 32'hFFFF_FFFE;  ehi[3] = 32'd1;         elo[3] = 32'hFFFF_FFFD;
        ops[4] = 4'd4; av[4] = 32'hFFFF_FFFF; bv[4] = 32'd10;         ehi[4] = 32'd5;         elo[4] = 32'h1999_9999;
        for (int v = 0; v < 5; v++) begin
            E_MDUop = ops[v]; E_A = av[v]; E_B = bv[v]; D_MDU_use = 1'b0;
            #1;
            if (D_MDU_stall !== 1'b0) begin $display("FAIL div%0d_nonmdu_stall_c0: got %b want 0", v, D_MDU_stall); fails++; end
            checks++;
            for (int k = 1; k <= 10; k++) begin
                step();
                E_MDUop = 4'd0;
                #1;
                if (E_busy !== 1'b1) begin $display("FAIL div%0d_busy_c%0d: got %b want 1", v, k, E_busy); fails++; end
                checks++;
                if (D_MDU_stall !== 1'b0) begin $display("FAIL div%0d_nonmdu_stall_c%0d: got %b want 0", v, k, D_MDU_stall); fails++; end
                checks++;
            end
            step();
            if (E_busy !== 1'b0) begin $display("FAIL div%0d_busy_done: got %b want 0", v, E_busy); fails++; end
            checks++;
            if (E_HI !== ehi[v]) begin $display("FAIL div%0d_hi: got %h want %h", v, E_HI, ehi[v]); fails++; end
            checks++;
            if (E_LO !== elo[v]) begin $display("FAIL div%0d_lo: got %h want %h", v, E_LO, elo[v]); fails++; end
            checks++;
        end
    endtask

    // A div arriving mid-mult is ignored; a stalled second mult starts at N+1.
    task automatic test_back_to_back();
        E_MDUop = 4'd1; E_A = 32'd5; E_B = 32'd7; D_MDU_use = 1'b1;
        step();
        E_MDUop = 4'd3; E_A = 32'd100; E_B = 32'd0;
        #1;
        if (D_MDU_stall !== 1'b1) begin $display("FAIL b2b_stall_c1: got %b want 1", D_MDU_stall); fails++; end
        checks++;
        for (int k = 2; k <= 5; k++) begin
            step();
            E_MDUop = 4'd0;
        end
        step();
        E_MDUop = 4'd1; E_A = 32'hFFFF_FFFF; E_B = 32'hFFFF_FFFF; D_MDU_use = 1'b1;
        #1;
        if (E_busy !== 1'b0) begin $display("FAIL b2b_busy_c6: got %b want 0", E_busy); fails++; end
        checks++;
        if (E_LO !== 32'd35 || E_HI !== 32'd0) begin $display("FAIL b2b_first_result: got %h_%h want 00000000_00000023", E_HI, E_LO); fails++; end
        checks++;
        if (D_MDU_stall !== 1'b1) begin $display("FAIL b2b_stall_start: got %b want 1", D_MDU_stall); fails++; end
        checks++;
        step();
        E_MDUop = 4'd0; D_MDU_use = 1'b0;
        #1;
        if (E_busy !== 1'b1) begin $display("FAIL b2b_second_busy: got %b want 1", E_busy); fails++; end
        checks++;
        for (int k = 2; k <= 5; k++) step();
        step();
        if (E_HI !== 32'd0 || E_LO !== 32'd1) begin $display("FAIL b2b_second_result: got %h_%h want 00000000_00000001", E_HI, E_LO); fails++; end
        checks++;
    endtask

    task automatic test_mthi_mtlo();
        E_MDUop = 4'd5; E_A = 32'h1234_5678; D_MDU_use = 1'b1;
        #1;
        if (D_MDU_stall !== 1'b0) begin $display("FAIL mthi_stall: got %b want 0", D_MDU_stall); fails++; end
        checks++;
        step();
        E_MDUop = 4'd8; E_A = 32'd0;
        #1;
        if (E_MDU_out !== 32'd1) begin $display("FAIL mflo_out: got %h want 00000001", E_MDU_out); fails++; end
        checks++;
        step();
        E_MDUop = 4'd7;
        #1;
        if (E_MDU_out !== 32'h1234_5678) begin $display("FAIL mfhi_after_mthi: got %h want 12345678", E_MDU_out); fails++; end
        checks++;
        step();
        E_MDUop = 4'd6; E_A = 32'hCAFE_F00D;
        step();
        E_MDUop = 4'd8;
        #1;
        if (E_MDU_out !== 32'hCAFE_F00D) begin $display("FAIL mflo_after_mtlo: got %h want cafef00d", E_MDU_out); fails++; end
        checks++;
        E_MDUop = 4'd9;
        #1;
        if (E_MDU_out !== 32'd0) begin $display("FAIL out_op9: got %h want 0", E_MDU_out); fails++; end
        checks++;
        E_MDUop = 4'd0; D_MDU_use = 1'b0;
    endtask

    task automatic test_reset_abort();
        E_MDUop = 4'd3; E_A = 32'd100; E_B = 32'd7;
        step();
        E_MDUop = 4'd0;
        step();
        step();
        if (E_busy !== 1'b1) begin $display("FAIL abort_busy_c3: got %b want 1", E_busy); fails++; end
        checks++;
        reset = 1'b0;
        step();
        reset = 1'b1;
        if (E_busy !== 1'b0) begin $display("FAIL abort_busy: got %b want 0", E_busy); fails++; end
        checks++;
        if (E_HI !== 32'd0 || E_LO !== 32'd0) begin $display("FAIL abort_hilo: got %h_%h want 0_0", E_HI, E_LO); fails++; end
        checks++;
        for (int k = 0; k < 10; k++) step();
        if (E_HI !== 32'd0 || E_LO !== 32'd0 || E_busy !== 1'b0) begin
            $display("FAIL abort_no_late_write: got %h_%h busy %b want 0_0 busy 0", E_HI, E_LO, E_busy); fails++;
        end
        checks++;
        E_MDUop = 4'd2; E_A = 32'hFFFF_FFFF; E_B = 32'd2;
        step();
        E_MDUop = 4'd0;
        for (int k = 2; k <= 5; k++) step();
        step();
        if (E_HI !== 32'd1) begin $display("FAIL multu_hi: got %h want 00000001", E_HI); fails++; end
        checks++;
        if (E_LO !== 32'hFFFF_FFFE) begin $display("FAIL multu_lo: got %h want fffffffe", E_LO); fails++; end
        checks++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_back_to_back();
        test_mthi_mtlo();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mdu_sched.md
# mdu_sched

Multiply/divide scheduler for the five-stage MIPS pipeline. It sits in the E stage beside the ALU and owns the HI/LO register pair. It sequences multi-cycle mult/multu/div/divu operations with a down-counter and asserts a D-stage stall to the hazard logic. That stall holds back any decoded MDU instruction while the unit is occupied.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low; reset==0 at a rising edge clears all state
- E_MDUop  input  4  E-stage MDU operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 treated as none
- E_A  input  32  forwarded rs value (dividend, multiplicand, mthi/mtlo source)
- E_B  input  32  forwarded rt value (divisor, multiplier)
- D_MDU_use  input  1  D-stage instruction is any of opcodes 1-8
- E_MDU_out  output  32  HI when E_MDUop==7, LO when E_MDUop==8, else 0; combinational
- E_busy  output  1  registered; high while an operation is in flight
- D_MDU_stall  output  1  combinational stall request to the hazard unit
- E_HI, E_LO  output  32 each  current architectural HI/LO registers

## Operation
- States: IDLE, BUSY. A 4-bit counter `cnt` tracks remaining cycles; `res_hi` and `res_lo` hold the pending result.
- Start condition: `start` = state==IDLE && E_MDUop in {1..4}. At the edge where `start` is high:
  - compute the result from E_A/E_B into `res_hi`/`res_lo`;
  - load cnt with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4);
  - go to BUSY.
- BUSY: cnt decrements each edge. At the edge where cnt==1, HI←res_hi, LO←res_lo and the state returns to IDLE.
- Arithmetic:
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero (div or divu): HI=E_A, LO=32'hFFFF_FFFF.
  - div 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
- mthi/mtlo: in IDLE, the edge writes E_A into HI or LO. In BUSY they are ignored (the stall guarantees they never arrive).
- mult/div opcodes arriving in BUSY are ignored, with no restart and no counter change.
- D_MDU_stall = D_MDU_use && (start || state==BUSY).
- E_busy = (state==BUSY).
- Reset in mid-operation aborts the operation: state IDLE, cnt=0, result discarded, HI=LO=0.

## Timing
- Reset values: E_busy=0, HI=0, LO=0, cnt=0, res_hi=res_lo=0, state IDLE. D_MDU_stall=0 and E_MDU_out=0 unless their combinational inputs drive them.
- Let cycle 0 be the cycle in which `start` is high.
  - E_busy is high in cycles 1..N, where N = MULT_CYCLES or DIV_CYCLES.
  - The new HI/LO are visible from cycle N+1.
  - D_MDU_stall can be high in cycles 0..N.
- An mfhi in D during cycle 0 enters E in cycle N+1 and reads the new HI.
- Back-to-back: a second mult in D during cycle 0 stalls and enters E in cycle N+1. It starts there, because state is IDLE.
- mthi in E in the same cycle that BUSY is leaving: impossible by the stall, so no priority is defined.
- Non-MDU D instructions are never stalled by this block.

## Test plan
- Reset: hold reset=0 for 2 cycles, then release -> HI=LO=0, E_busy=0, D_MDU_stall=0.
- mult with E_A=32'hFFFF_FFFE (-2), E_B=3:
  - E_busy high cycles 1..5;
  - cycle 6 HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA;
  - mfhi in D during cycles 0..5 stalls, and reads 32'hFFFF_FFFF in E.
- div with E_A=-7, E_B=2 -> after 10 busy cycles LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1). divu with 7 and 0 -> HI=7, LO=32'hFFFF_FFFF.
- mthi 32'h1234_5678 then mflo/mfhi in the next E cycles -> E_MDU_out = LO, then 32'h1234_5678. No stall, since the unit is IDLE.
- Reset driven low at busy cycle 3 of a div -> next cycle E_busy=0, HI=LO=0. A subsequent multu 32'hFFFF_FFFF×2 yields HI=1, LO=32'hFFFF_FFFE.
